// File: rtl/uart_cmd_receiver.sv
// Parses 'C' CMD ARG CHK command frames from the UART receiver, answers ACK/NAK,
// and holds a decoded command until the controller acknowledges it. 'X' is an emergency stop.
module uart_cmd_receiver #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic [3:0] cmd_arg,
  input  logic       cmd_ack,
  output logic       estop,
  output logic [7:0] err_count
);

  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] SOF_BYTE   = 8'h43;
  localparam logic [7:0] ESTOP_BYTE = 8'h58;
  localparam logic [7:0] ACK_BYTE   = 8'h41;
  localparam logic [7:0] NAK_BYTE   = 8'h4E;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GET_CMD   = 3'd1,
    GET_ARG   = 3'd2,
    GET_CHK   = 3'd3,
    CHECK     = 3'd4,
    SEND_RESP = 3'd5,
    HOLD_CMD  = 3'd6
  } state_t;

  state_t          state, state_d;
  logic [TO_W-1:0] to_cnt, to_cnt_d;
  logic [7:0]      cmd_byte, cmd_byte_d;
  logic [7:0]      arg_byte, arg_byte_d;
  logic [7:0]      chk_byte, chk_byte_d;
  logic            frame_good, frame_good_d;
  logic [7:0]      tx_data_d;
  logic            tx_valid_d;
  logic            cmd_valid_d;
  logic [2:0]      cmd_code_d;
  logic [3:0]      cmd_arg_d;
  logic            estop_d;
  logic [7:0]      err_count_d;

  logic [2:0] code_c;
  logic       good_c;
  logic       is_estop_c;
  logic       timeout_c;
  logic [7:0] err_inc_c;

  // Frame decode from the latched bytes
  always_comb begin
    code_c = 3'd0;
    case (cmd_byte)
      8'h46:   code_c = 3'd1;
      8'h4C:   code_c = 3'd2;
      8'h52:   code_c = 3'd3;
      8'h54:   code_c = 3'd4;
      8'h53:   code_c = 3'd5;
      default: code_c = 3'd0;
    endcase
    good_c = (code_c != 3'd0) && (arg_byte[7:4] == 4'd0) && (chk_byte == ~(cmd_byte ^ arg_byte));
  end

  assign is_estop_c = rx_valid && (rx_data == ESTOP_BYTE);
  assign timeout_c  = !rx_valid && (to_cnt == TO_LAST);
  assign err_inc_c  = (err_count == 8'hFF) ? 8'hFF : err_count + 8'd1;

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state;
    to_cnt_d     = to_cnt;
    cmd_byte_d   = cmd_byte;
    arg_byte_d   = arg_byte;
    chk_byte_d   = chk_byte;
    frame_good_d = frame_good;
    tx_data_d    = tx_data;
    tx_valid_d   = 1'b0;
    cmd_valid_d  = cmd_valid;
    cmd_code_d   = cmd_code;
    cmd_arg_d    = cmd_arg;
    estop_d      = 1'b0;
    err_count_d  = err_count;

    if (is_estop_c) begin
      // Emergency stop overrides everything, including a pending response
      estop_d     = 1'b1;
      cmd_valid_d = 1'b0;
      to_cnt_d    = '0;
      state_d     = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (rx_valid && (rx_data == SOF_BYTE)) begin
            to_cnt_d = '0;
            state_d  = GET_CMD;
          end
        end
        GET_CMD, GET_ARG, GET_CHK: begin
          if (rx_valid) begin
            to_cnt_d = '0;
            case (state)
              GET_CMD: begin
                cmd_byte_d = rx_data;
                state_d    = GET_ARG;
              end
              GET_ARG: begin
                arg_byte_d = rx_data;
                state_d    = GET_CHK;
              end
              default: begin
                chk_byte_d = rx_data;
                state_d    = CHECK;
              end
            endcase
          end else if (timeout_c) begin
            to_cnt_d    = '0;
            err_count_d = err_inc_c;
            state_d     = IDLE;
          end else begin
            to_cnt_d = to_cnt + TO_W'(1);
          end
        end
        CHECK: begin
          frame_good_d = good_c;
          tx_data_d    = good_c ? ACK_BYTE : NAK_BYTE;
          if (!good_c) err_count_d = err_inc_c;
          state_d = SEND_RESP;
        end
        SEND_RESP: begin
          if (tx_ready) begin
            tx_valid_d = 1'b1;
            if (frame_good) begin
              cmd_valid_d = 1'b1;
              cmd_code_d  = code_c;
              cmd_arg_d   = arg_byte[3:0];
              state_d     = HOLD_CMD;
            end else begin
              state_d = IDLE;
            end
          end
        end
        HOLD_CMD: begin
          if (cmd_ack) begin
            cmd_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      to_cnt     <= '0;
      cmd_byte   <= 8'h00;
      arg_byte   <= 8'h00;
      chk_byte   <= 8'h00;
      frame_good <= 1'b0;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_code   <= 3'd0;
      cmd_arg    <= 4'd0;
      estop      <= 1'b0;
      err_count  <= 8'h00;
    end else begin
      state      <= state_d;
      to_cnt     <= to_cnt_d;
      cmd_byte   <= cmd_byte_d;
      arg_byte   <= arg_byte_d;
      chk_byte   <= chk_byte_d;
      frame_good <= frame_good_d;
      tx_data    <= tx_data_d;
      tx_valid   <= tx_valid_d;
      cmd_valid  <= cmd_valid_d;
      cmd_code   <= cmd_code_d;
      cmd_arg    <= cmd_arg_d;
      estop      <= estop_d;
      err_count  <= err_count_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_receiver.sv
// Scoreboard bench for uart_cmd_receiver: stimulus pushes expected responses,
// a monitor pops and compares whenever the DUT strobes tx_valid, cmd_valid or estop.
module tb_uart_cmd_receiver;

  localparam int unsigned TO = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic [3:0] cmd_arg;
  logic       cmd_ack;
  logic       estop;
  logic [7:0] err_count;

  uart_cmd_receiver #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_arg(cmd_arg),
    .cmd_ack(cmd_ack), .estop(estop), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] code;
    logic [3:0] arg;
  } cmd_t;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_tx[$];
  cmd_t       exp_cmd[$];
  int exp_estop = 0;
  int exp_err = 0;
  int tx_seen = 0;
  int cmd_seen = 0;
  int estop_seen = 0;
  logic cmd_valid_q = 1'b0;

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules: command letters and their codes
  function automatic logic [2:0] code_of(input logic [7:0] c);
    case (c)
      "F": return 3'd1;
      "L": return 3'd2;
      "R": return 3'd3;
      "T": return 3'd4;
      "S": return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [7:0] any_byte(input bit allow_sof);
    logic [7:0] b;
    do b = 8'($urandom);
    while (b == 8'h58 || (!allow_sof && b == 8'h43));
    return b;
  endfunction

  function automatic void bump_err();
    exp_err = (exp_err >= 255) ? 255 : exp_err + 1;
  endfunction

  // Monitor: pops expectations whenever the DUT presents an output event
  always @(negedge clk) begin
    if (!reset) begin
      cmd_valid_q = 1'b0;
    end else begin
      if (tx_valid) begin
        tx_seen++;
        if (exp_tx.size() == 0) cmp("tx_unexpected", 1, 0);
        else cmp("tx_data", int'(tx_data), int'(exp_tx.pop_front()));
      end
      if (cmd_valid && !cmd_valid_q) begin
        cmd_t e;
        cmd_seen++;
        if (exp_cmd.size() == 0) cmp("cmd_unexpected", 1, 0);
        else begin
          e = exp_cmd.pop_front();
          cmp("cmd_code", int'(cmd_code), int'(e.code));
          cmp("cmd_arg", int'(cmd_arg), int'(e.arg));
        end
      end
      if (estop) begin
        estop_seen++;
        cmp("estop_expected", (exp_estop > 0) ? 1 : 0, 1);
        if (exp_estop > 0) exp_estop--;
      end
      cmd_valid_q = cmd_valid;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k,
                              output bit good);
    cmd_t e;
    good = (code_of(c) != 3'd0) && (a <= 8'd15) && (k == ~(c ^ a));
    exp_tx.push_back(good ? 8'h41 : 8'h4E);
    if (good) begin
      e.code = code_of(c);
      e.arg  = a[3:0];
      exp_cmd.push_back(e);
    end else begin
      bump_err();
    end
  endtask

  task automatic wait_tx(input int target, input string name);
    for (int i = 0; i < 200; i++) begin
      if (tx_seen >= target) return;
      @(negedge clk);
    end
    cmp(name, tx_seen, target);
  endtask

  task automatic wait_cmd(input string name);
    for (int i = 0; i < 200; i++) begin
      if (cmd_valid) return;
      @(negedge clk);
    end
    cmp(name, int'(cmd_valid), 1);
  endtask

  task automatic do_ack(input int delay, input bit junk);
    for (int i = 0; i < delay; i++) begin
      if (junk && ($urandom % 2 == 0)) send_byte(any_byte(1'b1));
      else idle(1);
    end
    cmp("cmd_valid_held", int'(cmd_valid), 1);
    cmd_ack = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
    cmp("cmd_valid_after_ack", int'(cmd_valid), 0);
  endtask

  task automatic run_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k,
                           input int gap_max, input int ready_delay, input int ack_delay);
    int t0;
    bit good;
    t0 = tx_seen;
    expect_frame(c, a, k, good);
    tx_ready = (ready_delay == 0);
    send_byte(8'h43); idle($urandom_range(gap_max, 0));
    send_byte(c);     idle($urandom_range(gap_max, 0));
    send_byte(a);     idle($urandom_range(gap_max, 0));
    send_byte(k);
    if (ready_delay > 0) begin
      for (int i = 0; i < ready_delay; i++) begin
        if ($urandom % 3 == 0) send_byte(any_byte(1'b1));
        else idle(1);
      end
      cmp("no_tx_while_busy", tx_seen, t0);
      cmp("no_cmd_while_busy", int'(cmd_valid), 0);
      tx_ready = 1'b1;
    end
    wait_tx(t0 + 1, "tx_timeout");
    if (good) begin
      wait_cmd("cmd_timeout");
      do_ack(ack_delay, 1'b1);
      cmp("code_kept", int'(cmd_code), int'(code_of(c)));
    end else begin
      idle(2);
      cmp("no_cmd_on_bad", int'(cmd_valid), 0);
    end
    idle(1);
    cmp("err_count", int'(err_count), exp_err);
    tx_ready = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    bit good;
    logic [7:0] c, a, k;
    reset = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1; cmd_ack = 1'b0;
    #1;
    cmp("rst_tx_data", int'(tx_data), 0);
    cmp("rst_tx_valid", int'(tx_valid), 0);
    cmp("rst_cmd_valid", int'(cmd_valid), 0);
    cmp("rst_cmd_code", int'(cmd_code), 0);
    cmp("rst_cmd_arg", int'(cmd_arg), 0);
    cmp("rst_estop", int'(estop), 0);
    cmp("rst_err", int'(err_count), 0);
    idle(2);
    reset = 1'b1;
    idle(2);

    // Directed frames from the plan
    run_frame(8'h54, 8'h03, 8'hA8, 0, 0, 2);
    run_frame(8'h46, 8'h02, 8'h00, 0, 0, 0);
    run_frame(8'h4C, 8'h01, 8'hB2, 2, 0, 1);
    run_frame(8'h53, 8'h00, 8'hAC, 1, 20, 3);

    // Timeout after 'C','R' with a 100-cycle gap
    t0 = tx_seen;
    send_byte(8'h43); send_byte(8'h52);
    idle(TO);
    bump_err();
    idle(3);
    cmp("timeout_err", int'(err_count), exp_err);
    cmp("timeout_no_tx", tx_seen, t0);

    // Byte on the last allowed cycle keeps the frame alive
    expect_frame(8'h52, 8'h03, ~(8'h52 ^ 8'h03), good);
    send_byte(8'h43); send_byte(8'h52);
    idle(TO - 1);
    send_byte(8'h03);
    idle(TO - 1);
    send_byte(~(8'h52 ^ 8'h03));
    wait_tx(t0 + 1, "late_tx_timeout");
    wait_cmd("late_cmd_timeout");
    do_ack(0, 1'b0);
    cmp("late_err", int'(err_count), exp_err);

    // Emergency stop mid-frame
    t0 = tx_seen;
    send_byte(8'h43); send_byte(8'h46);
    exp_estop++;
    send_byte(8'h58);
    idle(2);
    cmp("estop_mid_count", estop_seen, 1);
    cmp("estop_mid_err", int'(err_count), exp_err);
    cmp("estop_mid_no_tx", tx_seen, t0);
    run_frame(8'h46, 8'h07, ~(8'h46 ^ 8'h07), 0, 0, 0);

    // Emergency stop while a command is held
    t0 = tx_seen;
    expect_frame(8'h54, 8'h09, ~(8'h54 ^ 8'h09), good);
    send_byte(8'h43); send_byte(8'h54); send_byte(8'h09); send_byte(~(8'h54 ^ 8'h09));
    wait_tx(t0 + 1, "hold_tx_timeout");
    wait_cmd("hold_cmd_timeout");
    exp_estop++;
    send_byte(8'h58);
    cmp("estop_hold_cmd_valid", int'(cmd_valid), 0);
    idle(2);
    cmp("estop_hold_count", estop_seen, 2);
    cmp("estop_hold_err", int'(err_count), exp_err);

    // Randomized frames, with idle junk and occasional idle-state estop
    for (int n = 0; n < 40; n++) begin
      if ($urandom % 4 == 0) begin
        send_byte(any_byte(1'b0));
        idle($urandom_range(2, 0));
      end
      if ($urandom % 8 == 0) begin
        exp_estop++;
        send_byte(8'h58);
        idle(1);
      end
      c = ($urandom % 4 != 0) ? code_of_letter($urandom % 5) : any_byte(1'b1);
      a = ($urandom % 5 != 0) ? 8'($urandom % 16) : any_byte(1'b1);
      k = ($urandom % 4 != 0) ? ~(c ^ a) : any_byte(1'b1);
      if (k == 8'h58) k = 8'h57;
      run_frame(c, a, k, 4, ($urandom % 3 == 0) ? $urandom_range(6, 1) : 0, $urandom_range(4, 0));
    end

    // Saturation of the error counter
    for (int n = 0; n < 260; n++) run_frame(8'h46, 8'h01, 8'h00, 0, 0, 0);
    cmp("err_saturated", int'(err_count), 255);

    // Asynchronous reset while waiting to send a response
    expect_frame(8'h53, 8'h00, 8'hAC, good);
    tx_ready = 1'b0;
    send_byte(8'h43); send_byte(8'h53); send_byte(8'h00); send_byte(8'hAC);
    idle(3);
    #2 reset = 1'b0;
    #1;
    cmp("arst_tx_data", int'(tx_data), 0);
    cmp("arst_tx_valid", int'(tx_valid), 0);
    cmp("arst_cmd_valid", int'(cmd_valid), 0);
    cmp("arst_cmd_code", int'(cmd_code), 0);
    cmp("arst_estop", int'(estop), 0);
    cmp("arst_err", int'(err_count), 0);
    exp_tx.delete();
    exp_cmd.delete();
    exp_err = 0;
    @(negedge clk);
    reset = 1'b1;
    tx_ready = 1'b1;
    t0 = tx_seen;
    send_byte(8'h46); send_byte(8'h02); send_byte(8'hFD); send_byte(8'h00);
    idle(5);
    cmp("post_rst_no_tx", tx_seen, t0);
    cmp("post_rst_err", int'(err_count), 0);
    run_frame(8'h52, 8'h0F, ~(8'h52 ^ 8'h0F), 1, 0, 1);

    idle(3);
    cmp("tx_queue_drained", exp_tx.size(), 0);
    cmp("cmd_queue_drained", exp_cmd.size(), 0);
    cmp("estop_drained", exp_estop, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  function automatic logic [7:0] code_of_letter(input int unsigned i);
    case (i)
      0: return "F";
      1: return "L";
      2: return "R";
      3: return "T";
      default: return "S";
    endcase
  endfunction

endmodule
